wm8731_i2c_responder: RTL and testbench

Bus-functional I2C write-only responder that emulates the WM8731 codec control port. It sits on the simulation/loopback side of the codec config path and receives the 3-byte writes {device addr, reg addr + data[8], data[7:0]} produced by the config ROM/I2C master. It holds the codec's 10 x 9-bit register file so benches and on-chip checkers can confirm the configuration that actually reached the codec.

---
 rtl/wm8731_i2c_responder.sv | 196 +++++++++++++++++++
 tb/tb_wm8731_i2c_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8731_i2c_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wm8731_i2c_responder
//  Purpose  : Write-only I2C responder emulating the WM8731 control port.
//             Receives {dev addr, reg addr + data[8], data[7:0]} writes,
//             ACKs them and keeps the codec's 10 x 9-bit register file.
//  Revision : 1.0 - initial release
// ============================================================================
module wm8731_i2c_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       active,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEV     = 3'd1,
        S_DEV_ACK = 3'd2,
        S_B1      = 3'd3,
        S_B1_ACK  = 3'd4,
        S_B2      = 3'd5,
        S_B2_ACK  = 3'd6,
        S_IGNORE  = 3'd7
    } state_t;

    // Address that reloads every register with its power-on default.
    localparam logic [6:0] C_RESET_REG = 7'h0F;
    localparam int         C_NUM_REGS  = 10;

    // WM8731 power-on register values.
    function automatic logic [8:0] reg_default(input int idx);
        case (idx)
            0, 1:    reg_default = 9'h097;
            2, 3:    reg_default = 9'h079;
            4:       reg_default = 9'h00A;
            5:       reg_default = 9'h008;
            6:       reg_default = 9'h09F;
            7:       reg_default = 9'h00A;
            default: reg_default = 9'h000;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;
    logic [7:0]             w_byte;

    state_t                 r_state;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic [6:0]             r_reg_addr;
    logic                   r_data8;
    logic [8:0]             r_regs [C_NUM_REGS];

    // Synchronise the bus lines and keep a one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // Bus conditions are only recognised while SCL is stably high.
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    // Byte as it stands once the bit on this SCL rise is included.
    assign w_byte     = {r_shift, w_sda};

    // Protocol FSM, ACK driver, write commit and register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 7'd0;
            r_reg_addr <= 7'd0;
            r_data8    <= 1'b0;
            sda_oe     <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 7'd0;
            wr_data    <= 9'd0;
            busy       <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= reg_default(i);
            end
        end else begin
            wr_strobe <= 1'b0;
            if (w_start) begin
                busy      <= 1'b1;
                sda_oe    <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_state   <= S_DEV;
            end else if (w_stop) begin
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_DEV, S_B1, S_B2: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == S_DEV) begin
                                    if (w_byte[7:1] == DEV_ADDR && !w_byte[0]) begin
                                        r_state <= S_DEV_ACK;
                                    end else begin
                                        r_state <= S_IGNORE;
                                    end
                                end else if (r_state == S_B1) begin
                                    r_reg_addr <= w_byte[7:1];
                                    r_data8    <= w_byte[0];
                                    r_state    <= S_B1_ACK;
                                end else begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= r_reg_addr;
                                    wr_data   <= {r_data8, w_byte};
                                    if (r_reg_addr < 7'(C_NUM_REGS)) begin
                                        r_regs[r_reg_addr[3:0]] <= {r_data8, w_byte};
                                    end else if (r_reg_addr == C_RESET_REG) begin
                                        for (int i = 0; i < C_NUM_REGS; i++) begin
                                            r_regs[i] <= reg_default(i);
                                        end
                                    end
                                    r_state <= S_B2_ACK;
                                end
                            end
                        end
                    end
                    S_DEV_ACK, S_B1_ACK, S_B2_ACK: begin
                        // First SCL fall drives the ACK, the second ends the ACK clock.
                        if (w_scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                case (r_state)
                                    S_DEV_ACK: r_state <= S_B1;
                                    S_B1_ACK:  r_state <= S_B2;
                                    default:   r_state <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    default: begin
                        // IDLE and IGNORE wait for a bus condition.
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Combinational register read; unimplemented addresses read as zero.
    always_comb begin
        rd_data = 9'h000;
        if (rd_addr < 4'(C_NUM_REGS)) begin
            rd_data = r_regs[rd_addr];
        end
    end

    assign active = r_regs[9][0];

endmodule
`default_nettype wire

// File: tb/tb_wm8731_i2c_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wm8731_i2c_responder
//  Purpose  : Self-checking bench for wm8731_i2c_responder. An I2C master
//             drives directed and random write transactions; a transaction
//             level model predicts ACKs, committed writes and register state.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wm8731_i2c_responder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       active;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0]  m_regs [10];
    logic [15:0] exp_q [$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    wm8731_i2c_responder #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl       (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .active    (active),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: codec datasheet defaults and the effect of one committed write.
    task automatic model_defaults();
        m_regs[0] = 9'h097; m_regs[1] = 9'h097;
        m_regs[2] = 9'h079; m_regs[3] = 9'h079;
        m_regs[4] = 9'h00A; m_regs[5] = 9'h008;
        m_regs[6] = 9'h09F; m_regs[7] = 9'h00A;
        m_regs[8] = 9'h000; m_regs[9] = 9'h000;
    endtask

    task automatic model_write(input logic [6:0] a, input logic [8:0] d);
        exp_q.push_back({a, d});
        if (a < 7'd10) m_regs[a] = d;
        else if (a == 7'h0F) model_defaults();
    endtask

    // Monitor: every strobe must match the oldest predicted write.
    always @(negedge clk) begin : monitor
        logic [15:0] e;
        if (reset_n === 1'b1 && wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[15:9]));
                check("wr_data", 32'(wr_data), 32'(e[8:0]));
            end
        end
    end

    // Quarter SCL period: 5 clk, so SCL runs at 1/20 of clk.
    task automatic qw();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qw();
        scl   = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl   = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qw();
        scl   = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; qw();
            scl   = 1'b1; qw(); qw();
            scl   = 1'b0; qw();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; qw();
        scl   = 1'b1; qw();
        ack   = ~sda_line;
        qw();
        scl   = 1'b0; qw();
    endtask

    task automatic check_regs(input string tag);
        logic [8:0] exp;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            @(negedge clk);
            exp = (a < 10) ? m_regs[a] : 9'h000;
            check($sformatf("%s rd_data[%0d]", tag, a), 32'(rd_data), 32'(exp));
        end
        check({tag, " active"}, 32'(active), 32'(m_regs[9][0]));
    endtask

    // Three bytes plus optional trailing bytes, inside an already-open transfer.
    task automatic xfer_body(input logic [7:0] dev, input logic [7:0] b1,
                             input logic [7:0] b2, input int extra);
        logic ack;
        logic ok;
        ok = (dev == 8'h34);
        if (ok) model_write(b1[7:1], {b1[0], b2});
        send_byte(dev, ack); check("ack_dev", 32'(ack), 32'(ok));
        send_byte(b1, ack);  check("ack_b1", 32'(ack), 32'(ok));
        send_byte(b2, ack);  check("ack_b2", 32'(ack), 32'(ok));
        for (int i = 0; i < extra; i++) begin
            send_byte(8'($urandom), ack);
            check("ack_extra", 32'(ack), 32'd0);
        end
    endtask

    task automatic finish_txn(input string tag);
        i2c_stop();
        check({tag, " busy_after_stop"}, 32'(busy), 32'd0);
        check({tag, " strobe_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check_regs(tag);
    endtask

    task automatic write_txn(input string tag, input logic [7:0] dev, input logic [7:0] b1,
                             input logic [7:0] b2, input int extra);
        i2c_start();
        check({tag, " busy_start"}, 32'(busy), 32'd1);
        xfer_body(dev, b1, b2, extra);
        finish_txn(tag);
    endtask

    // Abort inside byte 2 or 3, then STOP or a repeated START with a full write.
    task automatic abort_txn(input string tag, input int at_byte, input int nbits, input bit restart);
        logic ack;
        i2c_start();
        send_byte(8'h34, ack);
        check({tag, " ack_dev"}, 32'(ack), 32'd1);
        if (at_byte == 3) begin
            send_byte(8'($urandom_range(0, 19)), ack);
            check({tag, " ack_b1"}, 32'(ack), 32'd1);
        end
        send_bits(8'($urandom), nbits);
        if (restart) begin
            i2c_start();
            check({tag, " busy_restart"}, 32'(busy), 32'd1);
            xfer_body(8'h34, {7'($urandom_range(0, 9)), 1'($urandom)}, 8'($urandom), 0);
        end
        finish_txn(tag);
    endtask

    function automatic logic [7:0] rand_b1();
        int r;
        logic [6:0] a;
        r = $urandom_range(0, 99);
        if (r < 65)      a = 7'($urandom_range(0, 9));
        else if (r < 80) a = 7'h0F;
        else             a = 7'($urandom_range(10, 127));
        return {a, 1'($urandom)};
    endfunction

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        logic ack;
        int   k;
        int   waited;
        reset_n = 1'b0;
        scl     = 1'b1;
        sda_m   = 1'b1;
        rd_addr = 4'd0;
        model_defaults();
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        check("reset sda_oe", 32'(sda_oe), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset wr_strobe", 32'(wr_strobe), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);
        check_regs("reset");

        write_txn("w7", 8'h34, 8'h0E, 8'h41, 0);
        write_txn("active", 8'h34, 8'h12, 8'h01, 0);
        write_txn("r0", 8'h34, 8'h00, 8'h17, 0);
        write_txn("reload", 8'h34, 8'h1E, 8'h00, 0);
        write_txn("badaddr", 8'h36, 8'h0E, 8'h55, 0);
        write_txn("readreq", 8'h35, 8'h0E, 8'h55, 0);
        write_txn("after_bad", 8'h34, 8'h0C, 8'h33, 0);
        abort_txn("abort_b3", 3, 4, 1'b0);
        abort_txn("abort_b2", 2, 4, 1'b0);
        write_txn("extra", 8'h34, 8'h08, 8'h5A, 1);

        // Reset while the responder is holding the DEV ACK.
        i2c_start();
        send_bits(8'h34, 8);
        waited = 0;
        while (sda_oe !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ack_before_reset", 32'(sda_oe), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_async sda_oe", 32'(sda_oe), 32'd0);
        check("reset_async busy", 32'(busy), 32'd0);
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        model_defaults();
        exp_q.delete();
        repeat (4) @(posedge clk);
        check_regs("after_reset");

        for (int t = 0; t < 30; t++) begin
            k = $urandom_range(0, 9);
            if (k <= 5) begin
                write_txn("rand_wr", ($urandom_range(0, 9) < 7) ? 8'h34 : 8'($urandom),
                          rand_b1(), 8'($urandom), 0);
            end else if (k == 6) begin
                write_txn("rand_extra", 8'h34, rand_b1(), 8'($urandom), $urandom_range(1, 2));
            end else begin
                abort_txn("rand_abort", $urandom_range(2, 3), $urandom_range(1, 7), k == 9);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
